// File: rtl/piece_sequencer.sv
// Falling-brick sequencer. It spawns the brick, applies gravity and player moves,
// commits only collision-free tries, and locks, clears and counts lines.
`timescale 1ns/1ps
`ifndef POS_LEN
`define POS_LEN 10
`endif
`ifndef DIR_LEN
`define DIR_LEN 2
`endif
`ifndef BRICK_LEN
`define BRICK_LEN 3
`endif

module piece_sequencer #(
  parameter int GRAVITY_TICKS = 32,
  parameter int SPAWN_X       = 6,
  parameter int SPAWN_Y       = 18,
  parameter int LINES_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_left,
  input  logic                  cmd_right,
  input  logic                  cmd_rot,
  input  logic                  cmd_soft,
  input  logic                  cmd_hard,
  input  logic [`BRICK_LEN-1:0] next_type,
  input  logic                  collided,
  input  logic [`POS_LEN-1:0]   drop_pos,
  input  logic [2:0]            num_to_clear,
  output logic [`POS_LEN-1:0]   cur_pos,
  output logic [`DIR_LEN-1:0]   cur_dir,
  output logic [`BRICK_LEN-1:0] cur_type,
  output logic [`POS_LEN-1:0]   try_pos,
  output logic [`DIR_LEN-1:0]   try_dir,
  output logic [`BRICK_LEN-1:0] try_type,
  output logic                  place_en,
  output logic                  clear_en,
  output logic [LINES_W-1:0]    lines,
  output logic                  game_over,
  output logic [2:0]            state_dbg
);
  localparam int PW = `POS_LEN;
  localparam int XW = PW / 2;
  localparam int YW = PW - XW;
  localparam int CW = (GRAVITY_TICKS > 2) ? $clog2(GRAVITY_TICKS) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(GRAVITY_TICKS - 1);
  localparam logic [PW-1:0] SPAWN_POS = {XW'(SPAWN_X), YW'(SPAWN_Y)};
  localparam logic [`BRICK_LEN-1:0] BRICK_I = `BRICK_LEN'(1);
  localparam logic [LINES_W-1:0] LINES_MAX = '1;

  typedef enum logic [2:0] {
    S_SPAWN = 3'd0, S_SPAWN_CHK = 3'd1, S_IDLE = 3'd2, S_CHECK = 3'd3,
    S_LOCK = 3'd4, S_CLEAR = 3'd5, S_OVER = 3'd6
  } state_t;
  typedef enum logic {MK_NONE = 1'b0, MK_DOWN = 1'b1} move_t;

  state_t                state_q, state_d;
  move_t                 mk_q, mk_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  tick_q, tick_d, tick_wrap;
  logic [PW-1:0]         cur_pos_q, cur_pos_d, try_pos_q, try_pos_d;
  logic [`DIR_LEN-1:0]   cur_dir_q, cur_dir_d, try_dir_q, try_dir_d;
  logic [`BRICK_LEN-1:0] cur_type_q, cur_type_d, try_type_q, try_type_d;
  logic                  place_q, place_d, clear_q, clear_d, over_q, over_d;
  logic [LINES_W-1:0]    lines_q, lines_d;
  logic [LINES_W:0]      lines_sum;
  logic [XW-1:0]         cur_x;
  logic [YW-1:0]         cur_y;

  assign cur_x     = cur_pos_q[PW-1:YW];
  assign cur_y     = cur_pos_q[YW-1:0];
  assign tick_wrap = (state_q != S_OVER) && (cnt_q == CNT_TOP);
  assign lines_sum = {1'b0, lines_q} + (LINES_W + 1)'(num_to_clear);

  always_comb begin
    state_d    = state_q;
    mk_d       = mk_q;
    cnt_d      = cnt_q;
    tick_d     = tick_q;
    cur_pos_d  = cur_pos_q;
    cur_dir_d  = cur_dir_q;
    cur_type_d = cur_type_q;
    try_pos_d  = try_pos_q;
    try_dir_d  = try_dir_q;
    try_type_d = try_type_q;
    place_d    = 1'b0;
    clear_d    = 1'b0;
    over_d     = over_q;
    lines_d    = lines_q;

    if (state_q != S_OVER) begin
      if (tick_wrap) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    case (state_q)
      S_SPAWN: begin
        try_pos_d  = SPAWN_POS;
        try_dir_d  = '0;
        try_type_d = next_type;
        state_d    = S_SPAWN_CHK;
      end
      S_SPAWN_CHK: begin
        if (collided) begin
          over_d  = 1'b1;
          state_d = S_OVER;
        end else begin
          cur_pos_d  = try_pos_q;
          cur_dir_d  = try_dir_q;
          cur_type_d = try_type_q;
          state_d    = S_IDLE;
        end
      end
      S_IDLE: begin
        try_pos_d  = cur_pos_q;
        try_dir_d  = cur_dir_q;
        try_type_d = cur_type_q;
        mk_d       = MK_NONE;
        state_d    = S_CHECK;
        if (cmd_hard) begin
          try_pos_d  = try_pos_q;
          try_dir_d  = try_dir_q;
          try_type_d = try_type_q;
          cur_pos_d  = drop_pos;
          place_d    = 1'b1;
          state_d    = S_LOCK;
        end else if (cmd_rot) begin
          try_dir_d = cur_dir_q + 1'b1;
        end else if (cmd_left) begin
          try_pos_d = {cur_x - 1'b1, cur_y};
        end else if (cmd_right) begin
          try_pos_d = {cur_x + 1'b1, cur_y};
        end else if (cmd_soft || tick_q) begin
          try_pos_d = {cur_x, cur_y - 1'b1};
          mk_d      = MK_DOWN;
          // A tick landing in this same cycle re-arms rather than being lost.
          tick_d    = tick_wrap;
        end else begin
          try_pos_d  = try_pos_q;
          try_dir_d  = try_dir_q;
          try_type_d = try_type_q;
          mk_d       = mk_q;
          state_d    = S_IDLE;
        end
      end
      S_CHECK: begin
        mk_d    = MK_NONE;
        state_d = S_IDLE;
        if (!collided) begin
          cur_pos_d  = try_pos_q;
          cur_dir_d  = try_dir_q;
          cur_type_d = try_type_q;
        end else if (mk_q == MK_DOWN) begin
          place_d = 1'b1;
          state_d = S_LOCK;
        end
      end
      S_LOCK: begin
        clear_d = 1'b1;
        state_d = S_CLEAR;
      end
      S_CLEAR: begin
        lines_d = lines_sum[LINES_W] ? LINES_MAX : lines_sum[LINES_W-1:0];
        cnt_d   = '0;
        tick_d  = 1'b0;
        state_d = S_SPAWN;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_SPAWN;
      mk_q       <= MK_NONE;
      cnt_q      <= '0;
      tick_q     <= 1'b0;
      cur_pos_q  <= SPAWN_POS;
      cur_dir_q  <= '0;
      cur_type_q <= BRICK_I;
      try_pos_q  <= SPAWN_POS;
      try_dir_q  <= '0;
      try_type_q <= BRICK_I;
      place_q    <= 1'b0;
      clear_q    <= 1'b0;
      over_q     <= 1'b0;
      lines_q    <= '0;
    end else begin
      state_q    <= state_d;
      mk_q       <= mk_d;
      cnt_q      <= cnt_d;
      tick_q     <= tick_d;
      cur_pos_q  <= cur_pos_d;
      cur_dir_q  <= cur_dir_d;
      cur_type_q <= cur_type_d;
      try_pos_q  <= try_pos_d;
      try_dir_q  <= try_dir_d;
      try_type_q <= try_type_d;
      place_q    <= place_d;
      clear_q    <= clear_d;
      over_q     <= over_d;
      lines_q    <= lines_d;
    end
  end

  assign cur_pos   = cur_pos_q;
  assign cur_dir   = cur_dir_q;
  assign cur_type  = cur_type_q;
  assign try_pos   = try_pos_q;
  assign try_dir   = try_dir_q;
  assign try_type  = try_type_q;
  assign place_en  = place_q;
  assign clear_en  = clear_q;
  assign lines     = lines_q;
  assign game_over = over_q;
  assign state_dbg = state_q;
endmodule

// File: tb/tb_piece_sequencer.sv
// Directed bench for piece_sequencer: spawn, moves, rotation wrap, gravity lock,
// hard drop, game over and asynchronous reset.
`timescale 1ns/1ps

module tb_piece_sequencer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_left, cmd_right, cmd_rot, cmd_soft, cmd_hard;
  logic [2:0] next_type;
  logic       collided;
  logic [9:0] drop_pos;
  logic [2:0] num_to_clear;
  logic [9:0] cur_pos, try_pos;
  logic [1:0] cur_dir, try_dir;
  logic [2:0] cur_type, try_type;
  logic       place_en, clear_en, game_over;
  logic [15:0] lines;
  logic [2:0] state_dbg;

  int n_chk = 0;
  int n_pass = 0;

  piece_sequencer #(.GRAVITY_TICKS(16), .SPAWN_X(6), .SPAWN_Y(18), .LINES_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_left(cmd_left), .cmd_right(cmd_right), .cmd_rot(cmd_rot),
    .cmd_soft(cmd_soft), .cmd_hard(cmd_hard),
    .next_type(next_type), .collided(collided), .drop_pos(drop_pos),
    .num_to_clear(num_to_clear),
    .cur_pos(cur_pos), .cur_dir(cur_dir), .cur_type(cur_type),
    .try_pos(try_pos), .try_dir(try_dir), .try_type(try_type),
    .place_en(place_en), .clear_en(clear_en), .lines(lines),
    .game_over(game_over), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] mp(input int x, input int y);
    return {5'(x), 5'(y)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    {cmd_left, cmd_right, cmd_rot, cmd_soft, cmd_hard} = '0;
    next_type = 3'd3; collided = 1'b0; drop_pos = '0; num_to_clear = 3'd0;
    #12;
    chk("rst_state", state_dbg, 0);
    chk("rst_cur_pos", cur_pos, mp(6, 18));
    chk("rst_cur_type", cur_type, 1);
    chk("rst_try_type", try_type, 1);
    chk("rst_place", place_en, 0);
    chk("rst_lines", lines, 0);
    chk("rst_over", game_over, 0);
    @(posedge clk); #1; rst_n = 1'b1;

    step();                                   // edge 1
    chk("spawn_chk_state", state_dbg, 1);
    chk("spawn_try_type", try_type, 3);
    step();                                   // edge 2
    chk("idle_state", state_dbg, 2);
    chk("spawn_cur_pos", cur_pos, mp(6, 18));
    chk("spawn_cur_type", cur_type, 3);
    chk("spawn_place", place_en, 0);

    cmd_left = 1'b1; step(); cmd_left = 1'b0; // edge 3
    chk("left_check_state", state_dbg, 3);
    chk("left_try_pos", try_pos, mp(5, 18));
    chk("left_cur_held", cur_pos, mp(6, 18));
    step();                                   // edge 4
    chk("left_commit", cur_pos, mp(5, 18));

    cmd_left = 1'b1; step(); cmd_left = 1'b0; collided = 1'b1; // edge 5
    step(); collided = 1'b0;                  // edge 6
    chk("left_blocked_pos", cur_pos, mp(5, 18));
    chk("left_blocked_state", state_dbg, 2);

    for (int i = 0; i < 3; i++) begin         // edges 7..12
      cmd_rot = 1'b1; step(); cmd_rot = 1'b0; step();
    end
    chk("rot_dir3", cur_dir, 3);

    cmd_rot = 1'b1; cmd_right = 1'b1; step(); // edge 13
    cmd_rot = 1'b0; cmd_right = 1'b0;
    chk("rot_wrap_try_dir", try_dir, 0);
    chk("rot_pri_try_pos", try_pos, mp(5, 18));
    step();                                   // edge 14
    chk("rot_commit_dir", cur_dir, 0);
    chk("rot_commit_pos", cur_pos, mp(5, 18));

    step(); step();                           // edges 15,16: tick becomes pending
    chk("pre_tick_state", state_dbg, 2);
    step();                                   // edge 17: tick consumed
    chk("tick_check_state", state_dbg, 3);
    chk("tick_try_pos", try_pos, mp(5, 17));
    collided = 1'b1; num_to_clear = 3'd2;
    step(); collided = 1'b0;                  // edge 18
    chk("lock_state", state_dbg, 4);
    chk("lock_place", place_en, 1);
    chk("lock_no_clear", clear_en, 0);
    next_type = 3'd5;
    step();                                   // edge 19
    chk("clear_state", state_dbg, 5);
    chk("clear_no_place", place_en, 0);
    chk("clear_strobe", clear_en, 1);
    step();                                   // edge 20
    chk("lines_2", lines, 2);
    chk("clear_drop", clear_en, 0);
    chk("respawn_state", state_dbg, 0);
    step(); step();                           // edges 21,22
    chk("respawn_type", cur_type, 5);
    chk("respawn_pos", cur_pos, mp(6, 18));

    drop_pos = mp(6, 2); cmd_hard = 1'b1; step(); cmd_hard = 1'b0; // edge 23
    chk("hard_pos", cur_pos, mp(6, 2));
    chk("hard_place", place_en, 1);
    chk("hard_state", state_dbg, 4);
    step(); step(); step();                   // edges 24..26
    chk("hard_lines", lines, 4);
    chk("hard_spawn_chk", state_dbg, 1);

    collided = 1'b1; step(); collided = 1'b0; // edge 27
    chk("over_flag", game_over, 1);
    chk("over_state", state_dbg, 6);
    cmd_left = 1'b1; step(); cmd_left = 1'b0;
    cmd_hard = 1'b1; step(); cmd_hard = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("over_hold_state", state_dbg, 6);
    chk("over_hold_pos", cur_pos, mp(6, 2));
    chk("over_hold_try", try_pos, mp(6, 18));
    chk("over_hold_place", place_en, 0);
    chk("over_hold_lines", lines, 4);

    #2 rst_n = 1'b0; #1;
    chk("rearm_state", state_dbg, 0);
    chk("rearm_over", game_over, 0);
    chk("rearm_lines", lines, 0);
    chk("rearm_type", cur_type, 1);

    @(posedge clk); #1; rst_n = 1'b1;
    step(); step();
    chk("rearm_idle", state_dbg, 2);
    drop_pos = mp(3, 1); cmd_hard = 1'b1; step(); cmd_hard = 1'b0;
    chk("mid_lock_place", place_en, 1);
    #2 rst_n = 1'b0; #1;
    chk("async_place_drop", place_en, 0);
    chk("async_state", state_dbg, 0);
    chk("async_pos", cur_pos, mp(6, 18));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
